// File: rtl/gate_truth_table_checker_if.sv
// Stimulus/response bundle between the gate-block checker and its surroundings.
// The master side issues start and returns the gate outputs; the slave side is the checker.
interface gate_truth_table_checker_if;
  logic       start_i;
  logic [6:0] y_in_i;
  logic       a_o;
  logic       b_o;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic [7:0] err_count_o;
  logic [3:0] fail_vec_o;

  modport master (
    output start_i, y_in_i,
    input  a_o, b_o, busy_o, done_o, pass_o, err_count_o, fail_vec_o
  );

  modport slave (
    input  start_i, y_in_i,
    output a_o, b_o, busy_o, done_o, pass_o, err_count_o, fail_vec_o
  );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Sweeps a/b through all four combinations and compares y_in against the golden truth table.
// Optional GATECHK_STOP_ON_FAIL_EN: halt on the first mismatch with a/b frozen for probing.
module gate_truth_table_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1
) (
  input logic                       clk,
  input logic                       rst,
  gate_truth_table_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 32'd1);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 32'd1);

  // Golden y1..y7 word for each {a,b}.
  function automatic logic [6:0] golden_word(input logic [1:0] combo);
    logic [6:0] w;
    case (combo)
      2'b00:   w = 7'h1D;
      2'b01:   w = 7'h2A;
      2'b10:   w = 7'h3A;
      2'b11:   w = 7'h61;
      default: w = 7'h00;
    endcase
    return w;
  endfunction

  state_e     state_q;
  logic [3:0] settle_q;
  logic [1:0] combo_q;
  logic [7:0] pass_cnt_q;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] err_count_q;
  logic [3:0] fail_vec_q;

  logic       mismatch_s;
  logic       last_s;
  logic       stop_s;
  logic [7:0] err_count_d;
  logic [3:0] fail_vec_d;
  logic [1:0] combo_d;

  // Compare path and saturating error update used at the end of SAMPLE.
  always_comb begin
    mismatch_s  = (bus.y_in_i != golden_word(combo_q));
    last_s      = (combo_q == 2'd3) && (pass_cnt_q == PASS_LAST);
    combo_d     = combo_q + 2'd1;
    err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
    fail_vec_d  = fail_vec_q | (4'b0001 << combo_q);
`ifdef GATECHK_STOP_ON_FAIL_EN
    stop_s      = mismatch_s;
`else
    stop_s      = 1'b0;
`endif
  end

  // Sequencer FSM with all status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      settle_q    <= 4'd0;
      combo_q     <= 2'd0;
      pass_cnt_q  <= 8'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 8'd0;
      fail_vec_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start_i) begin
            state_q     <= DRIVE;
            settle_q    <= 4'd0;
            combo_q     <= 2'd0;
            pass_cnt_q  <= 8'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 8'd0;
            fail_vec_q  <= 4'd0;
          end else begin
            state_q <= state_q;
          end
        end
        DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= SAMPLE;
            settle_q <= 4'd0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch_s) begin
            err_count_q <= err_count_d;
            fail_vec_q  <= fail_vec_d;
          end else begin
            err_count_q <= err_count_q;
          end
          // On an early stop a/b keep the failing combination.
          if (stop_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
          end else if (last_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_q == 8'd0) && !mismatch_s;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
          end else begin
            state_q <= DRIVE;
            combo_q <= combo_d;
            a_q     <= combo_d[1];
            b_q     <= combo_d[0];
            if (combo_q == 2'd3) begin
              pass_cnt_q <= pass_cnt_q + 8'd1;
            end else begin
              pass_cnt_q <= pass_cnt_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_o         = a_q;
  assign bus.b_o         = b_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.pass_o      = pass_q;
  assign bus.err_count_o = err_count_q;
  assign bus.fail_vec_o  = fail_vec_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: three checker instances (different SETTLE/PASSES) around a golden gate model.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc;
  logic [3:0] bad0 = 4'b0000;
  logic [2:0] start_v = 3'b000;
  logic [2:0] busy_v;
  logic [2:0] done_v;

  always #5 clk = ~clk;

  gate_truth_table_checker_if i0 ();
  gate_truth_table_checker_if i1 ();
  gate_truth_table_checker_if i2 ();

  gate_truth_table_checker #(.SETTLE(2), .PASSES(1))   d0 (.clk(clk), .rst(rst), .bus(i0.slave));
  gate_truth_table_checker #(.SETTLE(2), .PASSES(2))   d1 (.clk(clk), .rst(rst), .bus(i1.slave));
  gate_truth_table_checker #(.SETTLE(1), .PASSES(255)) d2 (.clk(clk), .rst(rst), .bus(i2.slave));

  function automatic logic [6:0] gate_model(input logic a, input logic b);
    logic [6:0] y;
    case ({a, b})
      2'b00:   y = 7'h1D;
      2'b01:   y = 7'h2A;
      2'b10:   y = 7'h3A;
      default: y = 7'h61;
    endcase
    return y;
  endfunction

  // d0: golden model with per-combination fault injection; d1: wrong only at 00; d2: stuck at 0.
  assign i0.y_in_i = gate_model(i0.a_o, i0.b_o) ^ {6'b0, bad0[{i0.a_o, i0.b_o}]};
  assign i1.y_in_i = ({i1.a_o, i1.b_o} == 2'b00) ? 7'h1C : gate_model(i1.a_o, i1.b_o);
  assign i2.y_in_i = 7'h00;

  assign i0.start_i = start_v[0];
  assign i1.start_i = start_v[1];
  assign i2.start_i = start_v[2];
  assign busy_v = {i2.busy_o, i1.busy_o, i0.busy_o};
  assign done_v = {i2.done_o, i1.done_o, i0.done_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start instance k, optionally re-pulse start at cycle pulse_at, count busy cycles until done.
  task automatic run(input int k, input int pulse_at, input int limit, output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    @(negedge clk); start_v[k] = 1'b1;
    @(negedge clk); start_v[k] = 1'b0;
    while (!done_v[k] && n < limit) begin
      if (busy_v[k]) busy_cycles++;
      start_v[k] = (n == pulse_at);
      n++;
      @(negedge clk);
    end
    start_v[k] = 1'b0;
    check("run_done_within_bound", {31'b0, done_v[k]}, 32'd1);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ctl", {27'b0, i0.a_o, i0.b_o, i0.busy_o, i0.done_o, i0.pass_o}, 32'd0);
    check("rst_err", {24'b0, i0.err_count_o}, 32'd0);
    check("rst_fail", {28'b0, i0.fail_vec_o}, 32'd0);
    rst = 1'b0;

    // Clean sweep: a/b 00,01,10,11 three cycles each, busy exactly 12 cycles.
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("sweep_c%0d", k), {29'b0, i0.busy_o, i0.a_o, i0.b_o}, {29'b0, 1'b1, 2'(k / 3)});
      @(negedge clk);
    end
    check("sweep_end_ctl", {27'b0, i0.a_o, i0.b_o, i0.busy_o, i0.done_o, i0.pass_o}, 32'b00011);
    check("sweep_end_err", {24'b0, i0.err_count_o}, 32'd0);
    check("sweep_end_fail", {28'b0, i0.fail_vec_o}, 32'd0);

    // y_in wrong at combo 00 only, two sweeps.
    run(1, -1, 100, cyc);
`ifdef GATECHK_STOP_ON_FAIL_EN
    check("p2_busy", cyc, 32'd3);
    check("p2_err", {24'b0, i1.err_count_o}, 32'd1);
`else
    check("p2_busy", cyc, 32'd24);
    check("p2_err", {24'b0, i1.err_count_o}, 32'd2);
`endif
    check("p2_fail", {28'b0, i1.fail_vec_o}, 32'b0001);
    check("p2_pass", {31'b0, i1.pass_o}, 32'd0);

    // Stuck-at-zero outputs over 255 sweeps: error count saturates.
    run(2, -1, 2100, cyc);
`ifdef GATECHK_STOP_ON_FAIL_EN
    check("sat_err", {24'b0, i2.err_count_o}, 32'd1);
    check("sat_fail", {28'b0, i2.fail_vec_o}, 32'b0001);
`else
    check("sat_busy", cyc, 32'd2040);
    check("sat_err", {24'b0, i2.err_count_o}, 32'd255);
    check("sat_fail", {28'b0, i2.fail_vec_o}, 32'b1111);
`endif
    check("sat_pass", {31'b0, i2.pass_o}, 32'd0);

    // Reset in the first DRIVE cycle of combo 10 clears everything in the same cycle.
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_ab", {30'b0, i0.a_o, i0.b_o}, 32'b10);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ctl", {27'b0, i0.a_o, i0.b_o, i0.busy_o, i0.done_o, i0.pass_o}, 32'd0);
    check("mid_rst_i1", {20'b0, i1.done_o, i1.err_count_o, i1.fail_vec_o[2:0]}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run(0, -1, 100, cyc);
    check("post_rst_busy", cyc, 32'd12);
    check("post_rst_pass", {31'b0, i0.pass_o}, 32'd1);

    // Start re-pulsed mid-run is ignored; fault injected at combo 01.
    bad0 = 4'b0010;
    run(0, 4, 100, cyc);
`ifdef GATECHK_STOP_ON_FAIL_EN
    check("repulse_busy", cyc, 32'd6);
    check("repulse_ab", {30'b0, i0.a_o, i0.b_o}, 32'b01);
`else
    check("repulse_busy", cyc, 32'd12);
    check("repulse_ab", {30'b0, i0.a_o, i0.b_o}, 32'b00);
`endif
    check("repulse_err", {24'b0, i0.err_count_o}, 32'd1);
    check("repulse_fail", {28'b0, i0.fail_vec_o}, 32'b0010);
    check("repulse_pass", {31'b0, i0.pass_o}, 32'd0);

    // Start in DONE clears results and begins a new clean run.
    bad0 = 4'b0000;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    check("restart_ctl", {27'b0, i0.a_o, i0.b_o, i0.busy_o, i0.done_o, i0.pass_o}, 32'b00100);
    check("restart_err", {20'b0, i0.err_count_o, i0.fail_vec_o}, 32'd0);
    repeat (12) @(negedge clk);
    check("restart_done", {29'b0, i0.busy_o, i0.done_o, i0.pass_o}, 32'b011);

    // Fault only at combo 10.
    bad0 = 4'b0100;
    run(0, -1, 100, cyc);
`ifdef GATECHK_STOP_ON_FAIL_EN
    check("c10_busy", cyc, 32'd9);
    repeat (3) @(negedge clk);
    check("c10_ab_frozen", {30'b0, i0.a_o, i0.b_o}, 32'b10);
`else
    check("c10_busy", cyc, 32'd12);
    check("c10_ab", {30'b0, i0.a_o, i0.b_o}, 32'b00);
`endif
    check("c10_err", {24'b0, i0.err_count_o}, 32'd1);
    check("c10_fail", {28'b0, i0.fail_vec_o}, 32'b0100);
    check("c10_pass", {31'b0, i0.pass_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
